branch_lut_loader: RTL and testbench
====================================

// Module: branch_lut_loader
// PURPOSE
//  Writer side of the branch-target lookup: a 16-entry, D-bit target table loaded at run time over a byte stream.
//  The fetch stage reads it combinationally with a 4-bit index, exactly as with the fixed table.
//  Sits between the host/boot byte source and PC/fetch logic; the loader rewrites entries without re-synthesis.
// PARAMETERS
//  D        10   target width (PC width), 9..16
//  ENTRIES  16   table depth; index width AW = $clog2(ENTRIES) = 4
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low; table and FSM return to defaults
//  in_data    in   8   load byte stream
//  in_valid   in   1   in_data valid this cycle
//  in_ready   out  1   loader accepts byte (transfer = in_valid & in_ready)
//  abort      in   1   drop the partially received record, return to IDLE
//  lock       in   1   when high, completed records are rejected (no table write)
//  rd_addr    in   4   fetch-side index
//  rd_target  out  D   lut[rd_addr], combinational
//  wr_done    out  1   1-cycle pulse: a record was written to the table
//  err        out  1   sticky: a record was rejected; cleared only by reset
//  busy       out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset values: table = DEFAULT_LUT; FSM = IDLE; in_ready=1; wr_done=0; err=0; busy=0.
//  Record = 3 bytes: IDX (bits[3:0]=index, [7:4] must be 0), LO (target[7:0]), HI (target[D-1:8] in low bits, rest 0).
//  FSM: IDLE -xfer-> GOT_IDX -xfer-> GOT_LO -xfer-> COMMIT -> IDLE.
//  in_ready = 1 in IDLE/GOT_IDX/GOT_LO, 0 in COMMIT. One record per 4 cycles at full rate.
//  COMMIT: if record legal and lock=0, write lut[idx] at the edge ending COMMIT; wr_done=1 during the cycle after.
//   Illegal (IDX[7:4]!=0, or HI bits above D-1 nonzero) or lock=1 -> no write, err<=1, wr_done stays 0.
//  Read: rd_target = lut[rd_addr], pure mux, no bypass. The new value is visible from the cycle after COMMIT.
//  abort (any state) -> IDLE next edge, no write, err unchanged. abort has priority over a simultaneous transfer.
//  in_valid low mid-record: FSM holds state indefinitely, with no timeout.
//  Same index written twice: last write wins.
//  lock is sampled only in COMMIT; toggling it mid-record is legal.
//  Async reset mid-record: partial record lost, table restored to DEFAULT_LUT, in_ready=1 right after deassertion.
//  Writes never change any entry other than lut[idx].
// STRUCTURE
//  Package branch_lut_pkg:
//   typedef enum logic [1:0] {IDLE, GOT_IDX, GOT_LO, COMMIT} ld_state_t;
//   localparam logic [9:0] DEFAULT_LUT[16] = {0,11,80,121,55,109,101,118,1,20,95,0,0,0,0,0}.
//   localparam REC_BYTES=3.
//  Sub-module lut_regfile: ENTRIES x D flops with async reset to DEFAULT_LUT, 1 write port (we, waddr, wdata), 1 comb read port.
//  The top holds the FSM, index/data holding registers, the legality check, and the wr_done/err flags.
// TESTING
//  1 Reset, no writes: sweep rd_addr 0..15 -> 0,11,80,121,55,109,101,118,1,20,95,0,0,0,0,0.
//  2 Stream 0x09,0x34,0x01 back-to-back -> in_ready low for 1 cycle (COMMIT); wr_done pulse; lut[9]=0x134=308; others unchanged.
//  3 Stream 0x12,0x00,0x00 (bad idx) and 0x03,0xFF,0x04 (HI bit2 set, D=10) -> err=1, lut[3] stays 121, no wr_done.
//  4 lock=1, stream 0x00,0x05,0x00 -> lut[0] stays 0, err=1. Then lock=0, same record -> lut[0]=5, wr_done.
//  5 Send 0x04,0x10, assert abort with a concurrent 3rd byte -> IDLE, no write; next full record 0x04,0x10,0x00 -> lut[4]=16.
//  6 Write lut[2]=200, stall in_valid 10 cycles mid-record, then assert reset -> lut[2]=80, err=0, busy=0.
//    Random idle gaps on in_valid: scoreboard matches a reference model.

Source files
------------

// File: rtl/branch_lut_pkg.sv
// Shared types and constants for the run-time loadable branch-target table.
package branch_lut_pkg;

   // Loader FSM: one state per received record byte, plus the write cycle.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GOT_IDX = 2'd1,
      GOT_LO  = 2'd2,
      COMMIT  = 2'd3
   } ld_state_t;

   // Bytes per record: IDX, LO, HI.
   localparam int REC_BYTES = 3;

   // Table contents after reset; matches the former fixed table.
   localparam logic [9:0] DEFAULT_LUT [16] = '{
      10'd0,   10'd11,  10'd80,  10'd121,
      10'd55,  10'd109, 10'd101, 10'd118,
      10'd1,   10'd20,  10'd95,  10'd0,
      10'd0,   10'd0,   10'd0,   10'd0
   };

   // The HI byte carries target[d-1:8] in its low bits; anything above must be zero.
   function automatic logic hi_legal(input logic [7:0] hi, input int d);
      return (hi >> (d - 8)) == 8'd0;
   endfunction

endpackage

// File: rtl/branch_lut_loader_lut_regfile.sv
// ENTRIES x D target table: one write port, one combinational read port.
module lut_regfile
   import branch_lut_pkg::*;
#(
   parameter  int D       = 10,
   parameter  int ENTRIES = 16,
   localparam int AW      = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [D-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [D-1:0]  rdata
);

   logic [D-1:0] mem [ENTRIES];

   // Entries beyond the default table come up as zero.
   function automatic logic [D-1:0] reset_value(input int i);
      logic [3:0] k;
      k = i[3:0];
      if (i < 16) return D'(DEFAULT_LUT[k]);
      return '0;
   endfunction

   // Table storage: restored to the default contents on reset, one entry written per cycle.
   // NOTE: this array is built from flops, not RAM, so a full async reset is legal and required
   // here -- the fetch path must see the default table immediately after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= reset_value(i);
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Fetch-side read: pure mux, no write bypass.
   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_lut_loader.sv
// Byte-stream loader for the branch-target table: collects IDX/LO/HI records,
// checks them and writes the table, while the fetch side reads it combinationally.
module branch_lut_loader
   import branch_lut_pkg::*;
#(
   parameter  int D       = 10,
   parameter  int ENTRIES = 16,
   localparam int AW      = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          abort,
   input  logic          lock,
   input  logic [AW-1:0] rd_addr,
   output logic [D-1:0]  rd_target,
   output logic          wr_done,
   output logic          err,
   output logic          busy
);

   ld_state_t    state, state_n;
   logic [7:0]   idx_q;
   logic [7:0]   lo_q;
   logic [7:0]   hi_q;
   logic         xfer;
   logic         rec_legal;
   logic         in_commit;
   logic         we;
   logic         reject;
   logic [15:0]  rec_word;

   assign in_ready  = (state != COMMIT);
   assign busy      = (state != IDLE);
   assign xfer      = in_valid & in_ready;

   // A record is legal when the index fits the table and HI has no bits above the target width.
   assign rec_legal = ((idx_q >> AW) == 8'd0) && hi_legal(hi_q, D);
   assign rec_word  = {hi_q, lo_q};

   // An abort landing on COMMIT cancels the write and leaves err alone.
   assign in_commit = (state == COMMIT) && !abort;
   assign we        = in_commit && rec_legal && !lock;
   assign reject    = in_commit && !(rec_legal && !lock);

   // Next-state logic; abort wins over any transfer in the same cycle.
   // NOTE: state_n gets a default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (xfer) state_n = GOT_IDX;
            GOT_IDX: if (xfer) state_n = GOT_LO;
            GOT_LO:  if (xfer) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // FSM state, record holding registers and status flags.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         idx_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         wr_done <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         wr_done <= we;
         if (reject) err <= 1'b1;
         if (xfer && !abort) begin
            case (state)
               IDLE:    idx_q <= in_data;
               GOT_IDX: lo_q  <= in_data;
               GOT_LO:  hi_q  <= in_data;
               default: ;
            endcase
         end
      end
   end

   lut_regfile #(
      .D       (D),
      .ENTRIES (ENTRIES)
   ) u_lut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (idx_q[AW-1:0]),
      .wdata (rec_word[D-1:0]),
      .raddr (rd_addr),
      .rdata (rd_target)
   );

endmodule

// File: tb/tb_branch_lut_loader.sv
// Directed bench for branch_lut_loader with a small reference table model.
module tb_branch_lut_loader;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       abort;
   logic       lock;
   logic [3:0] rd_addr;
   logic [9:0] rd_target;
   logic       wr_done;
   logic       err;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [9:0] model [16];
   logic       model_err;

   localparam logic [9:0] DEF [16] = '{10'd0, 10'd11, 10'd80, 10'd121, 10'd55, 10'd109, 10'd101,
                                       10'd118, 10'd1, 10'd20, 10'd95, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};

   branch_lut_loader #(.D(10), .ENTRIES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .abort     (abort),
      .lock      (lock),
      .rd_addr   (rd_addr),
      .rd_target (rd_target),
      .wr_done   (wr_done),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_default();
      for (int i = 0; i < 16; i++) model[i] = DEF[i];
      model_err = 1'b0;
   endtask

   // Compare every table entry against the model; returns aligned to a falling edge.
   task automatic sweep(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #0.25;
         check($sformatf("%s_lut%0d", tag, i), {22'd0, rd_target}, {22'd0, model[i]});
      end
      @(negedge clk);
   endtask

   // Offer one byte after 'gap' idle cycles; returns on the falling edge after it was taken.
   task automatic put_byte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Send a full record and check the COMMIT cycle, the write pulse and err.
   task automatic send_rec(input logic [7:0] idx, input logic [7:0] lo, input logic [7:0] hi, input int gap);
      logic exp_write;
      put_byte(idx, gap);
      put_byte(lo, gap);
      put_byte(hi, gap);
      check("ready_in_commit", 32'(in_ready), 32'd0);
      check("busy_in_commit", 32'(busy), 32'd1);
      exp_write = (idx[7:4] == 4'd0) && (hi[7:2] == 6'd0) && !lock;
      @(negedge clk);
      check("wr_done", 32'(wr_done), 32'(exp_write));
      check("ready_after_commit", 32'(in_ready), 32'd1);
      if (exp_write) model[idx[3:0]] = {hi[1:0], lo};
      else model_err = 1'b1;
      check("err", 32'(err), 32'(model_err));
   endtask

   initial begin
      reset    = 1'b0;
      in_data  = 8'd0;
      in_valid = 1'b0;
      abort    = 1'b0;
      lock     = 1'b0;
      rd_addr  = 4'd0;
      model_default();

      // Reset state and default table.
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_wr_done", 32'(wr_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      sweep("reset");

      // Legal record: lut[9] = 0x134.
      send_rec(8'h09, 8'h34, 8'h01, 0);
      @(negedge clk);
      check("wr_done_one_cycle", 32'(wr_done), 32'd0);
      check("lut9_value", 32'(model[9]), 32'd308);
      sweep("legal");

      // Illegal index, then illegal HI bits.
      send_rec(8'h12, 8'h00, 8'h00, 0);
      send_rec(8'h03, 8'hFF, 8'h04, 0);
      sweep("illegal");

      // Locked record rejected, then accepted once unlocked.
      lock = 1'b1;
      send_rec(8'h00, 8'h05, 8'h00, 0);
      lock = 1'b0;
      send_rec(8'h00, 8'h05, 8'h00, 0);
      sweep("lock");

      // Abort with a concurrent third byte.
      put_byte(8'h04, 0);
      put_byte(8'h10, 0);
      check("busy_before_abort", 32'(busy), 32'd1);
      in_data  = 8'h00;
      in_valid = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wr_done", 32'(wr_done), 32'd0);
      @(negedge clk);
      check("abort_no_pulse", 32'(wr_done), 32'd0);
      check("abort_err_kept", 32'(err), 32'(model_err));
      sweep("abort");
      send_rec(8'h04, 8'h10, 8'h00, 0);
      sweep("after_abort");

      // Write, stall mid-record, then async reset.
      send_rec(8'h02, 8'hC8, 8'h00, 0);
      put_byte(8'h05, 0);
      repeat (10) @(negedge clk);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_err", 32'(err), 32'd0);
      check("areset_ready", 32'(in_ready), 32'd1);
      rd_addr = 4'd2;
      #0.5;
      check("areset_lut2", 32'(rd_target), 32'd80);
      #1 reset = 1'b1;
      model_default();
      @(negedge clk);
      sweep("post_reset");

      // Records with random idle gaps, occasionally illegal.
      for (int n = 0; n < 16; n++) begin
         logic [7:0] ri, rl, rh;
         ri = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ri = ri | 8'h20;
         rl = 8'($urandom_range(0, 255));
         rh = ($urandom_range(0, 7) == 0) ? 8'h08 : 8'($urandom_range(0, 3));
         send_rec(ri, rl, rh, $urandom_range(0, 3));
      end
      sweep("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so a stuck run still ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
